// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, oversampled by b_tick at OVERSAMPLE x baud.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority voting per sample).
module uart_rx #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 b_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_busy,
   output logic                 frame_err
);

   localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TICK_W-1:0] START_D  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] BIT_D    = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                state, state_n;
   logic                  rx_q1, rx_s;
   logic [TICK_W-1:0]     tick_cnt, tick_n;
   logic [BIT_W-1:0]      bit_cnt, bit_n;
   logic [DATA_BITS-1:0]  shreg, shreg_n;
   logic                  armed, armed_n;
   logic [DATA_BITS-1:0]  rx_data_n;
   logic                  done_n, busy_n, ferr_n;
   logic                  sample_c;

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_q1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_q1 <= rx;
         rx_s  <= rx_q1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   // Keep rx_s from the two preceding ticks (D-2, D-1) for the vote at D
   always_ff @(posedge clk) begin
      if (reset) begin
         hist <= 2'b11;
      end else if (b_tick) begin
         hist <= {hist[0], rx_s};
      end
   end

   assign sample_c = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
   assign sample_c = rx_s;
`endif

   // State and datapath registers, outputs registered alongside
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         armed     <= 1'b1;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_n;
         bit_cnt   <= bit_n;
         shreg     <= shreg_n;
         armed     <= armed_n;
         rx_data   <= rx_data_n;
         rx_done   <= done_n;
         rx_busy   <= busy_n;
         frame_err <= ferr_n;
      end
   end

   // Next-state and next-output logic; counters only move on b_tick
   always_comb begin
      state_n   = state;
      tick_n    = tick_cnt;
      bit_n     = bit_cnt;
      shreg_n   = shreg;
      armed_n   = armed;
      rx_data_n = rx_data;
      done_n    = 1'b0;
      ferr_n    = frame_err;

      unique case (state)
         S_IDLE: begin
            // A tick coinciding with start entry is intentionally not counted
            if (armed && !rx_s) begin
               state_n = S_START;
               tick_n  = '0;
            end else if (rx_s) begin
               armed_n = 1'b1;
            end
         end
         S_START: begin
            if (b_tick) begin
               if (tick_cnt == START_D) begin
                  tick_n = '0;
                  if (sample_c) begin
                     state_n = S_IDLE;
                  end else begin
                     state_n = S_DATA;
                     bit_n   = '0;
                  end
               end else begin
                  tick_n = tick_cnt + TICK_W'(1);
               end
            end
         end
         S_DATA: begin
            if (b_tick) begin
               if (tick_cnt == BIT_D) begin
                  tick_n  = '0;
                  shreg_n = {sample_c, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == LAST_BIT) begin
                     state_n = S_STOP;
                     bit_n   = '0;
                  end else begin
                     bit_n = bit_cnt + BIT_W'(1);
                  end
               end else begin
                  tick_n = tick_cnt + TICK_W'(1);
               end
            end
         end
         S_STOP: begin
            // Leaving at the stop centre gives half a bit of margin for back-to-back frames
            if (b_tick) begin
               if (tick_cnt == BIT_D) begin
                  tick_n    = '0;
                  state_n   = S_IDLE;
                  rx_data_n = shreg;
                  done_n    = 1'b1;
                  ferr_n    = ~sample_c;
                  armed_n   = sample_c;
               end else begin
                  tick_n = tick_cnt + TICK_W'(1);
               end
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      busy_n = (state_n != S_IDLE);
   end

endmodule
